// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret sequencer driving the single CSR write port, then an IFU redirect.
// `define TRAP_MTVAL_EN adds an mtval write between mcause and mstatus (trap latency 6 instead of 5).
module trap_sequencer #(
  parameter int XLEN     = 32,
  parameter int IRQ_CODE = 7
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_tval,
  input  logic            i_irq,
  input  logic            i_illegal,
  input  logic            i_lfault,
  input  logic            i_ecall,
  input  logic            i_ebreak,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_mstatus,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  output logic            o_csr_wen,
  output logic [11:0]     o_csr_addr,
  output logic [XLEN-1:0] o_csr_wdata,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  input  logic            i_redirect_ready
);

`ifdef TRAP_MTVAL_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SAVE_EPC, S_SAVE_CAUSE, S_SAVE_TVAL, S_UPD_STATUS, S_RESTORE, S_REDIRECT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SAVE_EPC, S_SAVE_CAUSE, S_UPD_STATUS, S_RESTORE, S_REDIRECT
  } state_t;
`endif

  state_t          r_state;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_mstatus;

  logic            w_irq_eff;
  logic            w_trap;
  logic            w_accept;
  logic [XLEN-1:0] w_cause;
  logic            w_tval_keep;
  logic [XLEN-1:0] w_trap_status;
  logic [XLEN-1:0] w_mret_status;

  always_comb begin
    w_irq_eff   = i_irq & i_mstatus[3];
    w_trap      = w_irq_eff | i_illegal | i_lfault | i_ebreak | i_ecall;
    w_accept    = i_valid & o_ready & (w_trap | i_mret);
    w_tval_keep = 1'b0;
    w_cause     = '0;
    // Fixed priority; losing causes are simply dropped.
    if (w_irq_eff) begin
      w_cause = {1'b1, (XLEN-1)'(IRQ_CODE)};
    end else if (i_illegal) begin
      w_cause     = XLEN'(2);
      w_tval_keep = 1'b1;
    end else if (i_lfault) begin
      w_cause     = XLEN'(5);
      w_tval_keep = 1'b1;
    end else if (i_ebreak) begin
      w_cause = XLEN'(3);
    end else if (i_ecall) begin
      w_cause = XLEN'(11);
    end
  end

  always_comb begin
    w_trap_status        = r_mstatus;
    w_trap_status[7]     = r_mstatus[3];
    w_trap_status[3]     = 1'b0;
    w_trap_status[12:11] = 2'b11;
    w_mret_status        = i_mstatus;
    w_mret_status[3]     = i_mstatus[7];
    w_mret_status[7]     = 1'b1;
    w_mret_status[12:11] = 2'b11;
  end

`ifdef TRAP_MTVAL_EN
  logic [XLEN-1:0] r_tval;
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)
      r_tval <= '0;
    else if (w_accept)
      r_tval <= w_tval_keep ? i_tval : '0;
  end
`else
  logic w_unused_tval;
  assign w_unused_tval = ^{i_tval, w_tval_keep};
`endif

  // Outputs are registered: each transition loads the values seen during the next state.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cause       <= '0;
      r_mstatus     <= '0;
      o_ready       <= 1'b1;
      o_csr_wen     <= 1'b0;
      o_csr_addr    <= '0;
      o_csr_wdata   <= '0;
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
    end else begin
      o_csr_wen   <= 1'b0;
      o_csr_addr  <= '0;
      o_csr_wdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cause   <= w_cause;
            r_mstatus <= i_mstatus;
            o_ready   <= 1'b0;
            o_csr_wen <= 1'b1;
            if (w_trap) begin
              r_state     <= S_SAVE_EPC;
              o_csr_addr  <= 12'h341;
              o_csr_wdata <= i_pc;
            end else begin
              r_state     <= S_RESTORE;
              o_csr_addr  <= 12'h300;
              o_csr_wdata <= w_mret_status;
            end
          end
        end
        S_SAVE_EPC: begin
          r_state     <= S_SAVE_CAUSE;
          o_csr_wen   <= 1'b1;
          o_csr_addr  <= 12'h342;
          o_csr_wdata <= r_cause;
        end
        S_SAVE_CAUSE: begin
          o_csr_wen <= 1'b1;
`ifdef TRAP_MTVAL_EN
          r_state     <= S_SAVE_TVAL;
          o_csr_addr  <= 12'h343;
          o_csr_wdata <= r_tval;
        end
        S_SAVE_TVAL: begin
          o_csr_wen   <= 1'b1;
`endif
          r_state     <= S_UPD_STATUS;
          o_csr_addr  <= 12'h300;
          o_csr_wdata <= w_trap_status;
        end
        S_UPD_STATUS: begin
          r_state       <= S_REDIRECT;
          o_redirect    <= 1'b1;
          o_redirect_pc <= {i_mtvec[XLEN-1:2], 2'b00};
        end
        S_RESTORE: begin
          r_state       <= S_REDIRECT;
          o_redirect    <= 1'b1;
          o_redirect_pc <= i_mepc;
        end
        S_REDIRECT: begin
          if (i_redirect_ready) begin
            r_state       <= S_IDLE;
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;
            o_ready       <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          o_ready    <= 1'b1;
          o_redirect <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed + random checks of trap_sequencer against a cause/CSR-write list model.
module tb_trap_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid, irq, illegal, lfault, ecall, ebreak, mret, redirect_ready;
  logic [31:0] pc, tval, mstatus, mtvec, mepc;
  logic        ready, csr_wen, redirect;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  trap_sequencer #(.XLEN(32), .IRQ_CODE(7)) dut (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .o_ready(ready),
    .i_pc(pc), .i_tval(tval), .i_irq(irq), .i_illegal(illegal), .i_lfault(lfault),
    .i_ecall(ecall), .i_ebreak(ebreak), .i_mret(mret), .i_mstatus(mstatus),
    .i_mtvec(mtvec), .i_mepc(mepc), .o_csr_wen(csr_wen), .o_csr_addr(csr_addr),
    .o_csr_wdata(csr_wdata), .o_redirect(redirect), .o_redirect_pc(redirect_pc),
    .i_redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_events();
    valid = 0; irq = 0; illegal = 0; lfault = 0; ecall = 0; ebreak = 0; mret = 0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    chk({tag, "_wen"}, 64'(csr_wen), 64'd0);
    chk({tag, "_addr"}, 64'(csr_addr), 64'd0);
    chk({tag, "_redirect"}, 64'(redirect), 64'd0);
  endtask

  // ev = {irq, illegal, lfault, ebreak, ecall, mret}
  task automatic run_seq(input string tag, input logic [5:0] ev, input logic [31:0] a_pc,
                         input logic [31:0] a_tval, input logic [31:0] a_ms,
                         input logic [31:0] a_mtvec, input logic [31:0] a_mepc, input int dly);
    logic [31:0] cause_tab [5];
    logic        hit [5];
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] cause, exp_rpc;
    bit          trap, take;

    cause_tab = '{32'h8000_0007, 32'd2, 32'd5, 32'd3, 32'd11};
    hit = '{ev[5] & a_ms[3], ev[4], ev[3], ev[2], ev[1]};
    trap = 0; cause = 0;
    for (int i = 4; i >= 0; i--) if (hit[i]) begin trap = 1; cause = cause_tab[i]; end
    take = trap | ev[0];
    if (trap) begin
      wa.push_back(32'h341); wd.push_back(a_pc);
      wa.push_back(32'h342); wd.push_back(cause);
`ifdef TRAP_MTVAL_EN
      wa.push_back(32'h343); wd.push_back((cause == 2 || cause == 5) ? a_tval : 32'd0);
`endif
      wa.push_back(32'h300);
      wd.push_back((a_ms & ~32'h1888) | 32'h1800 | (a_ms[3] ? 32'h80 : 32'h0));
      exp_rpc = a_mtvec & ~32'h3;
    end else begin
      wa.push_back(32'h300);
      wd.push_back((a_ms & ~32'h1888) | 32'h1880 | (a_ms[7] ? 32'h8 : 32'h0));
      exp_rpc = a_mepc;
    end

    @(negedge clk);
    {irq, illegal, lfault, ebreak, ecall, mret} = ev;
    valid = 1; pc = a_pc; tval = a_tval; mstatus = a_ms; mtvec = a_mtvec; mepc = a_mepc;
    redirect_ready = (dly == 0);
    if (!take) begin
      @(negedge clk);
      clear_events();
      chk_idle_outputs({tag, "_noacc"});
      @(negedge clk);
      chk_idle_outputs({tag, "_noacc2"});
      return;
    end
    for (int k = 0; k < wa.size(); k++) begin
      @(negedge clk);
      // Busy: inputs wander and must not matter.
      valid = 1; {irq, illegal, lfault, ebreak, ecall, mret} = 6'($urandom);
      pc = $urandom; tval = $urandom; mstatus = $urandom;
      chk({tag, "_wr_ready"}, 64'(ready), 64'd0);
      chk({tag, "_wr_wen"}, 64'(csr_wen), 64'd1);
      chk({tag, "_wr_addr"}, 64'(csr_addr), 64'(wa[k]));
      chk({tag, "_wr_data"}, 64'(csr_wdata), 64'(wd[k]));
      chk({tag, "_wr_redir"}, 64'(redirect), 64'd0);
    end
    for (int d = 0; d <= dly; d++) begin
      @(negedge clk);
      if (d == 0) clear_events();
      chk({tag, "_rd_redir"}, 64'(redirect), 64'd1);
      chk({tag, "_rd_pc"}, 64'(redirect_pc), 64'(exp_rpc));
      chk({tag, "_rd_wen"}, 64'(csr_wen), 64'd0);
      chk({tag, "_rd_data"}, 64'(csr_wdata), 64'd0);
      chk({tag, "_rd_ready"}, 64'(ready), 64'd0);
      redirect_ready = (d == dly);
    end
    @(negedge clk);
    redirect_ready = 0;
    chk_idle_outputs({tag, "_done"});
  endtask

  initial begin
    clear_events();
    redirect_ready = 0; pc = 0; tval = 0; mstatus = 0; mtvec = 0; mepc = 0;
    rst = 1;
    #1;
    chk_idle_outputs("reset");
    chk("reset_wdata", 64'(csr_wdata), 64'd0);
    chk("reset_rpc", 64'(redirect_pc), 64'd0);
    @(negedge clk); rst = 0;

    run_seq("ecall", 6'b000010, 32'h8000_0100, 0, 32'h8, 32'h8000_1001, 0, 0);
    run_seq("irq_ill_ecall", 6'b110010, 32'h8000_0200, 0, 32'h8, 32'h8000_1000, 0, 0);
    run_seq("irq_masked_ill", 6'b110010, 32'h8000_0204, 0, 32'h0, 32'h8000_1000, 0, 0);
    run_seq("irq_masked_alone", 6'b100000, 32'h8000_0208, 0, 32'h0, 32'h8000_1000, 0, 0);
    run_seq("valid_no_event", 6'b000000, 32'h8000_020c, 0, 32'h8, 32'h8000_1000, 0, 0);
    run_seq("mret", 6'b000001, 32'h8000_0300, 0, 32'h1880, 32'h8000_1000, 32'h8000_0104, 0);
    run_seq("masked_irq_mret", 6'b100001, 32'h8000_0304, 0, 32'h80, 32'h8000_1000, 32'h8000_0400, 0);
    run_seq("redir_stall", 6'b000100, 32'h8000_0500, 0, 32'h8, 32'h8000_2002, 0, 3);
    run_seq("illegal_tval", 6'b010000, 32'h8000_0600, 32'hdead_beef, 32'h8, 32'h8000_1000, 0, 0);
    run_seq("lfault_tval", 6'b001000, 32'h8000_0604, 32'h1234_5678, 32'h0, 32'h8000_1000, 0, 1);

    // Asynchronous reset in the middle of SAVE_CAUSE.
    @(negedge clk);
    valid = 1; ecall = 1; pc = 32'h8000_0700; mstatus = 32'h8; mtvec = 32'h8000_1000;
    redirect_ready = 1;
    @(negedge clk);
    clear_events();
    chk("rst_epc_wen", 64'(csr_wen), 64'd1);
    chk("rst_epc_addr", 64'(csr_addr), 64'h341);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk_idle_outputs("rst_mid");
    chk("rst_mid_wdata", 64'(csr_wdata), 64'd0);
    chk("rst_mid_rpc", 64'(redirect_pc), 64'd0);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle_outputs("post_rst");
    end
    run_seq("post_rst_ecall", 6'b000010, 32'h8000_0800, 0, 32'h8, 32'h8000_1001, 0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] ev;
      for (int b = 0; b < 6; b++) ev[b] = ($urandom_range(0, 3) == 0);
      run_seq("rand", ev, $urandom & ~32'h3, $urandom, $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
